// File: rtl/ws2812_frame_tx_if.sv
// Upstream colour-word handshake for ws2812_frame_tx.
// valid/ready: a word transfers on a rising clk edge only when valid_i and ready_o are both high;
// the master may change rgb_i or drop valid_i freely while ready_o is low.
interface ws2812_frame_tx_if;
    logic [23:0] rgb_i;
    logic        valid_i;
    logic        ready_o;

    modport master (output rgb_i, output valid_i, input ready_o);
    modport slave  (input rgb_i, input valid_i, output ready_o);
endinterface

// File: rtl/ws2812_frame_tx.sv
// Buffers one frame of NUM_LEDS colour words and serialises it as WS2812 GRB
// pulse-width-coded bits, followed by a low latch period.
module ws2812_frame_tx #(
    parameter int NUM_LEDS     = 12,
    parameter int T0H          = 20,
    parameter int T1H          = 40,
    parameter int T_BIT        = 63,
    parameter int RESET_CYCLES = 2500,
    localparam int IDX_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    ws2812_frame_tx_if.slave up,
    output logic             data_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [1:0]       o_dbg_state,
    output logic [IDX_W-1:0] o_dbg_wr_idx
);
    localparam int CNT_W = $clog2(T_BIT);
    localparam int LAT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SEND  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [23:0]      r_buf [NUM_LEDS];
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_led;
    logic [4:0]       r_bit;
    logic [CNT_W-1:0] r_cnt;
    logic [LAT_W-1:0] r_lat;
    logic             r_data;
    logic             r_frame_done;

    logic        w_accept;
    logic        w_last_word;
    logic        w_bit_end;
    logic        w_last_bit;
    logic        w_last_led;
    logic        w_lat_end;
    logic [23:0] w_word;
    logic [23:0] w_grb;
    logic        w_cur_bit;

    assign w_accept    = (r_state == S_LOAD) && up.valid_i;
    assign w_last_word = (r_wr_idx == LAST_IDX);
    assign w_bit_end   = (r_cnt == CNT_LAST);
    assign w_last_bit  = (r_bit == 5'd0);
    assign w_last_led  = (r_led == LAST_IDX);
    assign w_lat_end   = (r_lat == LAT_LAST);
    assign w_word      = r_buf[r_led];
    // Wire order is G, R, B so bit 23 of the reordered word goes out first.
    assign w_grb       = {w_word[15:8], w_word[23:16], w_word[7:0]};
    assign w_cur_bit   = w_grb[r_bit];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        up.ready_o   = 1'b0;
        busy_o       = 1'b1;
        case (r_state)
            S_LOAD: begin
                up.ready_o = 1'b1;
                busy_o     = 1'b0;
                if (w_accept && w_last_word) w_next_state = S_SEND;
            end
            S_SEND: begin
                if (w_bit_end && w_last_bit && w_last_led) w_next_state = S_LATCH;
            end
            S_LATCH: begin
                if (w_lat_end) w_next_state = S_LOAD;
            end
            default: w_next_state = S_LOAD;
        endcase
    end

    // Buffer is deliberately not reset; a discarded partial frame is simply overwritten.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) r_buf[r_wr_idx] <= up.rgb_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx     <= '0;
            r_led        <= '0;
            r_bit        <= '0;
            r_cnt        <= '0;
            r_lat        <= '0;
            r_data       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_data       <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_last_word) begin
                            r_wr_idx <= '0;
                            r_led    <= '0;
                            r_bit    <= 5'd23;
                            r_cnt    <= '0;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    r_data <= w_cur_bit ? (r_cnt < T1H_C) : (r_cnt < T0H_C);
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_last_bit) begin
                            r_bit <= 5'd23;
                            if (w_last_led) begin
                                r_led <= '0;
                                r_lat <= '0;
                            end else begin
                                r_led <= r_led + 1'b1;
                            end
                        end else begin
                            r_bit <= r_bit - 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (w_lat_end) begin
                        r_lat        <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_o       = r_data;
    assign frame_done_o = r_frame_done;
    assign o_dbg_state  = r_state;
    assign o_dbg_wr_idx = r_wr_idx;
endmodule

// File: doc/ws2812_frame_tx.md
# ws2812_frame_tx

- Consumes 24-bit colour words, one per LED, from the colour pipeline. The `rgb` and `done` outputs of the colour calculator drive `rgb_i` and `valid_i`.
- Buffers one complete frame of `NUM_LEDS` words.
- Serialises the frame onto a single WS2812-style data line: GRB byte order, MSB first, pulse-width-coded bits.
- Follows the frame with a low latch period, then accepts the next frame.

## Interface
Parameters:
- `NUM_LEDS`, 12: number of colour words per frame; must be ≥ 1.
- `T0H`, 20: high time, in clk cycles, of a 0 bit.
- `T1H`, 40: high time, in clk cycles, of a 1 bit.
- `T_BIT`, 63: total bit period in cycles. Required: 0 < `T0H` < `T1H` < `T_BIT`.
- `RESET_CYCLES`, 2500: latch period in cycles with the line held low; must be ≥ 1.

Ports:
- `clk`, in, 1: single clock. Every register updates on the rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `rgb_i`, in, 24: colour word. R in [23:16], G in [15:8], B in [7:0].
- `valid_i`, in, 1: `rgb_i` is valid this cycle.
- `ready_o`, out, 1: block accepts a word this cycle.
- `data_o`, out, 1: serial LED data line. Registered.
- `busy_o`, out, 1: frame is transmitting or latching.
- `frame_done_o`, out, 1: one-cycle pulse at the end of the latch period.

## Operation
- Storage:
  - Buffer: `NUM_LEDS` × 24-bit registers.
  - Write index `wr_idx`, width `$clog2(NUM_LEDS)` (minimum 1).
  - Counters: LED index, bit index 23..0, cycle counter 0..`T_BIT`-1, latch counter 0..`RESET_CYCLES`-1.
- States: LOAD, SEND, LATCH. Reset state is LOAD.
- LOAD:
  - `ready_o`=1, `busy_o`=0.
  - Accept happens when `valid_i`=1 at a rising edge; `rgb_i` is written to `buf[wr_idx]`.
  - If `wr_idx` < `NUM_LEDS`-1: `wr_idx` increments.
  - Otherwise: `wr_idx` ← 0, go to SEND with LED index 0, bit index 23, cycle counter 0.
- SEND:
  - `ready_o`=0, `busy_o`=1. `valid_i` is ignored; upstream must hold or drop its word.
  - Current bit is `{G,R,B}` of `buf[led]`, at the bit index. Bit 23 is G[7]; bit 0 is B[0].
  - Each edge: `data_o` ← (cnt < (bit ? `T1H` : `T0H`)).
  - Cycle counter wraps at `T_BIT`-1. On wrap the bit index decrements.
  - After bit 0 the LED index increments and the bit index reloads to 23.
  - After the last bit of LED `NUM_LEDS`-1: go to LATCH with latch counter 0.
- LATCH:
  - `ready_o`=0, `busy_o`=1, `data_o` ← 0.
  - Stays for `RESET_CYCLES` cycles.
  - On the final cycle: `frame_done_o` ← 1 (registered, for one cycle) and state ← LOAD.
- Reset (at any time, including mid-SEND or mid-LATCH):
  - On the edge with `rst`=1: state ← LOAD, all counters ← 0, `data_o` ← 0, `frame_done_o` ← 0.
  - `valid_i` is ignored while `rst`=1.
  - Buffer contents are not cleared. A partial frame is discarded by resetting `wr_idx`.
- Arithmetic: all counters are unsigned with exact-width compares. No saturation is needed because every wrap is explicit.

## Timing
- Reset values: `data_o`=0, `frame_done_o`=0. `ready_o`=1 and `busy_o`=0, because both decode combinationally from state = LOAD.
- Frame start:
  - The last word is accepted at edge k.
  - `ready_o` falls in the cycle after edge k.
  - First `data_o` rising edge occurs at edge k+1.
- Bit waveform:
  - Each bit is high for exactly `T0H` or `T1H` cycles, then low for the remainder of `T_BIT`.
  - Bits are back-to-back with no gap between bits or between LEDs.
- SEND lasts exactly `NUM_LEDS`×24×`T_BIT` cycles.
- LATCH:
  - Lasts exactly `RESET_CYCLES` cycles.
  - `frame_done_o` is high on the cycle after the final latch cycle, i.e. the same cycle `ready_o` returns to 1.
- Throughput:
  - Minimum frame period = `NUM_LEDS` accepts + `NUM_LEDS`×24×`T_BIT` + `RESET_CYCLES` cycles.
  - Back-to-back accepts are allowed in LOAD.
- The handshake is valid/ready; a transfer occurs only when both are high at a rising edge.

## Test plan
Bench parameters: `NUM_LEDS`=2, `T0H`=2, `T1H`=4, `T_BIT`=6, `RESET_CYCLES`=10.
- **Reset:** hold `rst` for 3 cycles with `valid_i`=1 -> no accept occurs; after release `ready_o`=1, `busy_o`=0, `data_o`=0, `wr_idx`=0.
- **Byte order and pulse widths:** accept 24'hFF0000 then 24'h00FF01 ->
  - LED0 first 8 bits are 0s: 2 cycles high, 4 low each.
  - Next 8 bits are 1s: 4 high, 2 low each.
  - LED1 ends in 7 zero-bits then one 1-bit.
  - SEND lasts 288 cycles.
- **Frame end:** after SEND -> `data_o`=0 for 10 cycles, then `frame_done_o` high for exactly 1 cycle coincident with `ready_o`=1.
- **Handshake:** `valid_i` held high during SEND with a changing `rgb_i` -> no writes; the next frame's words are captured only after `ready_o` returns.
- **Mid-frame reset:** assert `rst` at bit 10 of LED0 -> `data_o`=0 on the next edge, `ready_o`=1, `busy_o`=0. A fresh two-word frame then transmits fully.
- **Partial load:** one word accepted, then `rst` -> `wr_idx`=0; the next two words form the frame and the first word is not transmitted.
